// File: rtl/alu_serial_deserializer.sv
// rtl/alu_serial_deserializer.sv - serial packet receiver that frames, CRC-checks and presents ALU commands
// Each packet is start(0), type, 8 bits MSB first, stop(1); eight DATA bytes then one CTL byte form a frame.
module alu_serial_deserializer #(
  parameter logic [3:0] CRC_INIT   = 4'b0000,
  parameter bit         CHECK_STOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        cmd_valid,
  output logic [31:0] cmd_a,
  output logic [31:0] cmd_b,
  output logic [2:0]  cmd_op,
  output logic        err_valid,
  output logic [2:0]  err_flags
);

  typedef enum logic [1:0] {S_IDLE, S_TYPE, S_BITS, S_STOP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_type;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [3:0]  r_byte_cnt;
  logic [63:0] r_data;
  logic [3:0]  r_crc;

  logic [2:0]  w_ctl_op;
  logic [3:0]  w_ctl_crc;
  logic [3:0]  w_crc_final;
  logic        w_stop_bad;
  logic        w_op_ok;
  logic [2:0]  w_flags;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
    logic fb;
    fb = c[3] ^ d;
    return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!sin) w_next = S_TYPE;
      S_TYPE: w_next = S_BITS;
      S_BITS: if (r_bit_cnt == 3'd7) w_next = S_STOP;
      S_STOP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // CRC over the data bits runs serially; the trailing {1, op} nibble is folded in at the CTL stop bit.
  assign w_ctl_op    = r_shift[6:4];
  assign w_ctl_crc   = r_shift[3:0];
  assign w_crc_final = crc_step(crc_step(crc_step(crc_step(r_crc, 1'b1),
                                w_ctl_op[2]), w_ctl_op[1]), w_ctl_op[0]);
  assign w_stop_bad  = CHECK_STOP && !sin;
  assign w_op_ok     = (w_ctl_op == 3'b000) || (w_ctl_op == 3'b001) ||
                       (w_ctl_op == 3'b100) || (w_ctl_op == 3'b101);

  always_comb begin
    w_flags = 3'b000;
    if (r_byte_cnt != 4'd8) begin
      w_flags = 3'b100;
    end else if (w_crc_final != w_ctl_crc) begin
      w_flags = 3'b010;
    end else if (!w_op_ok) begin
      w_flags = 3'b001;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type     <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_byte_cnt <= 4'd0;
      r_data     <= 64'd0;
      r_crc      <= CRC_INIT;
      cmd_valid  <= 1'b0;
      cmd_a      <= 32'd0;
      cmd_b      <= 32'd0;
      cmd_op     <= 3'd0;
      err_valid  <= 1'b0;
      err_flags  <= 3'd0;
    end else begin
      cmd_valid <= 1'b0;
      err_valid <= 1'b0;
      case (r_state)
        S_IDLE: r_bit_cnt <= 3'd0;
        S_TYPE: r_type <= sin;
        S_BITS: begin
          r_shift   <= {r_shift[6:0], sin};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (!r_type && (r_byte_cnt < 4'd8)) r_crc <= crc_step(r_crc, sin);
        end
        S_STOP: begin
          if (w_stop_bad) begin
            err_valid  <= 1'b1;
            err_flags  <= 3'b100;
            r_byte_cnt <= 4'd0;
            r_data     <= 64'd0;
            r_crc      <= CRC_INIT;
          end else if (!r_type) begin
            if (r_byte_cnt < 4'd8) r_data <= {r_data[55:0], r_shift};
            // Saturating at 9 remembers an overflow without wrapping back to a legal count.
            if (r_byte_cnt != 4'd9) r_byte_cnt <= r_byte_cnt + 4'd1;
          end else begin
            if (w_flags == 3'b000) begin
              cmd_valid <= 1'b1;
              cmd_b     <= r_data[63:32];
              cmd_a     <= r_data[31:0];
              cmd_op    <= w_ctl_op;
            end else begin
              err_valid <= 1'b1;
              err_flags <= w_flags;
            end
            r_byte_cnt <= 4'd0;
            r_data     <= 64'd0;
            r_crc      <= CRC_INIT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_deserializer.sv
// tb/tb_alu_serial_deserializer.sv - scoreboard bench for the serial command deserializer
module tb_alu_serial_deserializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sin;
  logic        cmd_valid;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_op;
  logic        err_valid;
  logic [2:0]  err_flags;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    bit          is_cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [2:0]  flags;
    int          cyc;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  logic [7:0] tx[0:15];

  alu_serial_deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .cmd_valid (cmd_valid),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .err_valid (err_valid),
    .err_flags (err_flags)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_crc(input logic [31:0] b, input logic [31:0] a,
                                           input logic [2:0] op);
    logic [67:0] m;
    logic [3:0]  c;
    logic        fb;
    m = {b, a, 1'b1, op};
    c = 4'b0000;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ m[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  function automatic logic [7:0] good_ctl(input logic [2:0] op);
    return {1'b0, op, model_crc({tx[0], tx[1], tx[2], tx[3]}, {tx[4], tx[5], tx[6], tx[7]}, op)};
  endfunction

  task automatic send_bit(input logic b);
    sin = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_packet(input logic typ, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_frame(input int n, input logic [7:0] ctl);
    exp_t e;
    for (int i = 0; i < n; i++) send_packet(1'b0, tx[i], 1'b1);
    send_packet(1'b1, ctl, 1'b1);
    e.b      = {tx[0], tx[1], tx[2], tx[3]};
    e.a      = {tx[4], tx[5], tx[6], tx[7]};
    e.op     = ctl[6:4];
    e.flags  = 3'b000;
    e.is_cmd = 1'b0;
    e.cyc    = cyc;
    if (n != 8) e.flags = 3'b100;
    else if (model_crc(e.b, e.a, e.op) != ctl[3:0]) e.flags = 3'b010;
    else if (!(e.op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.flags = 3'b001;
    else e.is_cmd = 1'b1;
    q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] flags);
    exp_t e;
    e.is_cmd = 1'b0;
    e.a      = 32'd0;
    e.b      = 32'd0;
    e.op     = 3'd0;
    e.flags  = flags;
    e.cyc    = cyc;
    q.push_back(e);
  endtask

  task automatic set_tx(input logic [63:0] v);
    for (int i = 0; i < 8; i++) tx[i] = v[63 - 8*i -: 8];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_valid"}, cmd_valid, 0);
    check({tag, "_err_valid"}, err_valid, 0);
    check({tag, "_cmd_a"}, cmd_a, 0);
    check({tag, "_cmd_b"}, cmd_b, 0);
    check({tag, "_cmd_op"}, cmd_op, 0);
    check({tag, "_err_flags"}, err_flags, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && err_valid) begin
        check("both_pulses", 1, 0);
      end else if (cmd_valid || err_valid) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          m_e = q.pop_front();
          check("latency", cyc, m_e.cyc);
          check("kind_cmd", cmd_valid, m_e.is_cmd);
          if (m_e.is_cmd) begin
            check("cmd_a", cmd_a, m_e.a);
            check("cmd_b", cmd_b, m_e.b);
            check("cmd_op", cmd_op, m_e.op);
          end else begin
            check("err_flags", err_flags, m_e.flags);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sin   = 1'b1;
    for (int i = 0; i < 16; i++) tx[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(3);

    set_tx(64'h0);
    send_frame(8, 8'h0B);
    idle(3);
    send_frame(8, 8'h47);
    idle(3);
    send_frame(8, 8'h46);
    idle(3);
    send_frame(7, 8'h0B);
    idle(3);
    send_frame(9, 8'h0B);
    idle(3);

    set_tx(64'h01020304_05060708);
    send_frame(8, good_ctl(3'b010));
    idle(3);
    send_frame(8, good_ctl(3'b101));
    idle(3);
    send_frame(8, good_ctl(3'b101) ^ 8'h01);
    idle(4);
    check("hold_cmd_b", cmd_b, 32'h01020304);
    check("hold_cmd_a", cmd_a, 32'h05060708);
    check("hold_cmd_op", cmd_op, 3'b101);

    set_tx(64'hDEADBEEF_12345678);
    send_frame(8, good_ctl(3'b001) | 8'h80);
    idle(3);

    for (int f = 0; f < 2; f++) begin
      set_tx({$urandom, $urandom});
      send_frame(8, good_ctl((f == 0) ? 3'b100 : 3'b000));
    end
    idle(3);

    send_packet(1'b0, 8'hA5, 1'b0);
    push_err(3'b100);
    idle(3);
    set_tx(64'h11223344_55667788);
    send_frame(8, good_ctl(3'b100));
    idle(3);

    set_tx(64'hCAFEF00D_0BADBEEF);
    for (int i = 0; i < 4; i++) send_packet(1'b0, tx[i], 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    sin   = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    set_tx(64'h89ABCDEF_01234567);
    send_frame(8, good_ctl(3'b101));

    idle(20);
    check("pending", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_serial_deserializer.md
Name: alu_serial_deserializer

Overview:
- Input stage that sits directly upstream of the ALU core.
- Receives the serial command stream on sin. Each packet is framed as start(0), type, 8 data bits MSB first, stop(1).
- Assembles 8 DATA bytes (B then A, MSB byte first) plus one CTL byte.
- Checks byte count, CRC and opcode, then presents either a validated {A, B, op} command or an error report to the core for one cycle.

Parameters:
- CRC_INIT, 4'b0000: initial value of the CRC-4 register.
- CHECK_STOP, 1: when 1, a stop bit sampled as 0 is a framing error.

Ports:
- clk  input  1  system clock; one serial bit per clock.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data in; idles high.
- cmd_valid  output  1  one-cycle pulse when a valid command is ready.
- cmd_a  output  32  operand A.
- cmd_b  output  32  operand B.
- cmd_op  output  3  opcode: 000 and, 001 or, 100 add, 101 sub.
- err_valid  output  1  one-cycle pulse when a frame is rejected.
- err_flags  output  3  {ERR_DATA, ERR_CRC, ERR_OP}; one-hot, priority order left to right.

Behaviour:
- Reset: every output is 0. FSM goes to IDLE. Bit counter, byte counter, shift registers and CRC are cleared.
  - Reset asserted mid-packet or mid-frame discards all partial data. No pulse is emitted.
- Packet FSM:
  - IDLE: waits for sin==0 (start bit), then goes to TYPE.
  - TYPE: samples sin (0 = DATA, 1 = CTL), then goes to BITS.
  - BITS: shifts in 8 bits MSB first (bit_cnt 0..7), then goes to STOP.
  - STOP: samples the stop bit, then returns to IDLE.
  - The next start bit may arrive on the clock immediately after the stop bit.
- Framing error: stop bit == 0 with CHECK_STOP == 1.
  - Emit err_valid with err_flags = 3'b100.
  - Clear the frame (byte count, data, CRC).
- DATA packet:
  - byte_cnt < 8: the byte is shifted into the 64-bit {B, A} register. The first byte received is B[31:24]; the eighth is A[7:0].
  - byte_cnt saturates at 9. Data beyond 8 bytes is not stored, but marks the overflow.
- CTL packet, layout {0, op[2:0], crc[3:0]}. Checks in priority order:
  - byte_cnt != 8 (including 0 and the saturated 9) -> ERR_DATA.
  - Otherwise, CRC mismatch -> ERR_CRC.
    - Compute CRC-4 with polynomial x^4+x+1 over the 68-bit message {B, A, 1'b1, op}, MSB first.
    - Per-bit update: fb = crc[3] ^ d; crc = {crc[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000).
    - CRC may be computed serially during reception or combinationally at CTL; the result must be identical.
  - Otherwise, op not in {000, 001, 100, 101} -> ERR_OP.
  - Otherwise -> cmd_valid.
  - Bit 7 of the CTL byte is ignored.
  - After any CTL packet, byte_cnt and the CRC are reset for the next frame.
- Output timing:
  - cmd_valid or err_valid pulses on the clock after the CTL stop bit is sampled (1-cycle latency).
  - cmd_valid and err_valid are never high together.
- Output holding:
  - cmd_a, cmd_b and cmd_op update only on cmd_valid and hold until the next valid command.
  - err_flags updates only on err_valid; it reads 0 when no error is flagged.
- Illegal type-bit sequences need no special handling. Only byte count and CTL content determine errors.

Test Plan:
- Send 8 DATA 8'h00 then CTL 8'h0B (A=B=0, op=and, CRC=1011) -> cmd_valid=1 one clock after the stop bit; cmd_a=0, cmd_b=0, cmd_op=000; err_valid stays 0.
- Send 8 DATA 8'h00 then CTL 8'h47 (op=add, CRC=0111) -> cmd_valid=1, cmd_op=100. Then send the same frame with CTL 8'h46 -> err_valid=1, err_flags=3'b010.
- Send 7 DATA bytes then CTL 8'h0B -> err_valid=1, err_flags=3'b100. Then send 9 DATA bytes then CTL -> err_flags=3'b100.
- Send B bytes 01,02,03,04 and A bytes 05,06,07,08 with op=010 and the correct CRC -> err_flags=3'b001.
  - Repeat with op=101 -> cmd_valid=1, cmd_b=32'h01020304, cmd_a=32'h05060708.
- Send two valid frames back-to-back with no idle bits between them -> two cmd_valid pulses, each with the correct operands.
- Assert rst_n low during the 5th data byte, release it, then send a full valid frame -> no pulse from the aborted frame; the new frame produces cmd_valid. All outputs read 0 while reset is held.
